// File: rtl/bus_timer_multi.sv
// rtl/bus_timer_multi.sv - multi-channel interval timer slave on the shared 8-bit processor bus
//
// A common prescaler produces one tick every PRE = CLK_FREQ_HZ/TICK_HZ clocks.
// Each channel counts ticks up to its PERIOD. It then sets EXPIRED and wraps,
// or stops if ONESHOT is set. Expiries of IRQ_EN channels raise SEND_INTERRUPT,
// which stays high until INTERRUPT_ACK.
//
// Register window: BASE_ADDR + 4*ch + k
//   k=0 CTRL   (R/W) bit0 EN, bit1 IRQ_EN, bit2 ONESHOT
//   k=1 PERIOD (R/W) period in ticks
//   k=2 COUNT  (R)   current count, any write clears it
//   k=3 STATUS (R)   bit0 EXPIRED, any write clears it
//
// Ports:
//   CLK            in     system clock, rising edge
//   RESET          in     asynchronous, active-high reset
//   BUS_DATA[7:0]  inout  shared data bus, driven the cycle after an in-window read
//   BUS_ADDR[7:0]  in     bus address
//   BUS_WE         in     1 = write cycle, 0 = read cycle
//   SEND_INTERRUPT out    level interrupt request, held until acknowledged
//   INTERRUPT_ACK  in     one-cycle acknowledge from the processor
module bus_timer_multi #(
   parameter logic [7:0] BASE_ADDR   = 8'hF0,
   parameter int         NUM_CH      = 2,
   parameter int         CLK_FREQ_HZ = 50_000_000,
   parameter int         TICK_HZ     = 1000
) (
   input  logic       CLK,
   input  logic       RESET,
   inout  wire  [7:0] BUS_DATA,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   output logic       SEND_INTERRUPT,
   input  logic       INTERRUPT_ACK
);

   localparam int            PRE      = CLK_FREQ_HZ / TICK_HZ;
   localparam int            PW       = (PRE > 1) ? $clog2(PRE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);
   localparam logic [8:0]    WIN_LO   = {1'b0, BASE_ADDR};
   localparam logic [8:0]    WIN_HI   = 9'(int'(BASE_ADDR) + 4 * NUM_CH - 1);

   logic [PW-1:0]     prescale;
   logic              tick;

   logic [2:0]        ctrl    [NUM_CH];
   logic [7:0]        period  [NUM_CH];
   logic [7:0]        count   [NUM_CH];
   logic              expired [NUM_CH];

   logic              in_window;
   logic [3:0]        offset;
   logic [1:0]        sel_ch;
   logic [1:0]        sel_reg;
   logic [NUM_CH-1:0] wr_sel;
   logic [NUM_CH-1:0] fire;
   logic              irq_event;
   logic [7:0]        read_mux;
   logic [7:0]        rd_data;
   logic              rd_en;

   // ---------------------------------------------------------------- prescaler
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         prescale <= '0;
      end else if (prescale == PRE_LAST) begin
         prescale <= '0;
      end else begin
         prescale <= prescale + 1'b1;
      end
   end

   assign tick = (prescale == PRE_LAST);

   // ------------------------------------------------------------ address decode
   assign in_window = ({1'b0, BUS_ADDR} >= WIN_LO) && ({1'b0, BUS_ADDR} <= WIN_HI);
   // The window spans at most 16 addresses, so the low nibble of the
   // difference is the full in-window offset.
   assign offset    = BUS_ADDR[3:0] - BASE_ADDR[3:0];
   assign sel_ch    = offset[3:2];
   assign sel_reg   = offset[1:0];

   always_comb begin
      wr_sel    = '0;
      fire      = '0;
      irq_event = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         wr_sel[c] = BUS_WE && in_window && (sel_ch == 2'(c));
         // ">=" rather than "==" so that shrinking PERIOD below the current
         // count expires on the next tick instead of running to 255.
         fire[c]   = tick && ctrl[c][0] && (period[c] != 8'd0) &&
                     (count[c] >= period[c] - 8'd1);
         if (fire[c] && ctrl[c][1]) begin
            irq_event = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- channels
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ctrl[c]    <= 3'b000;
            period[c]  <= 8'd0;
            count[c]   <= 8'd0;
            expired[c] <= 1'b0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            // A software CTRL write wins over the one-shot auto-disable.
            if (wr_sel[c] && sel_reg == 2'd0) begin
               ctrl[c] <= BUS_DATA[2:0];
            end else if (fire[c] && ctrl[c][2]) begin
               ctrl[c][0] <= 1'b0;
            end

            if (wr_sel[c] && sel_reg == 2'd1) begin
               period[c] <= BUS_DATA;
            end

            if (wr_sel[c] && sel_reg == 2'd2) begin
               count[c] <= 8'd0;
            end else if (fire[c]) begin
               count[c] <= 8'd0;
            end else if (tick && ctrl[c][0] && period[c] != 8'd0) begin
               count[c] <= count[c] + 8'd1;
            end

            // A new expiry wins over a STATUS-write clear in the same cycle.
            if (fire[c]) begin
               expired[c] <= 1'b1;
            end else if (wr_sel[c] && sel_reg == 2'd3) begin
               expired[c] <= 1'b0;
            end
         end
      end
   end

   // --------------------------------------------------------------- interrupt
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         SEND_INTERRUPT <= 1'b0;
      end else if (irq_event) begin
         SEND_INTERRUPT <= 1'b1;
      end else if (INTERRUPT_ACK) begin
         SEND_INTERRUPT <= 1'b0;
      end
   end

   // -------------------------------------------------------------- read path
   always_comb begin
      read_mux = 8'h00;
      for (int c = 0; c < NUM_CH; c++) begin
         if (sel_ch == 2'(c)) begin
            case (sel_reg)
               2'd0:    read_mux = {5'b00000, ctrl[c]};
               2'd1:    read_mux = period[c];
               2'd2:    read_mux = count[c];
               default: read_mux = {7'b0000000, expired[c]};
            endcase
         end
      end
   end

   // The drive enable is recomputed every cycle, so the bus is released one
   // cycle after the address leaves the window or WE rises.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rd_en   <= 1'b0;
         rd_data <= 8'h00;
      end else begin
         rd_en   <= in_window && !BUS_WE;
         rd_data <= read_mux;
      end
   end

   assign BUS_DATA = rd_en ? rd_data : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_bus_timer_multi.sv
// tb/tb_bus_timer_multi.sv - self-checking bench for bus_timer_multi
module tb_bus_timer_multi;

   localparam int PRE = 10;
   localparam int NCH = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] addr;
   logic       we;
   logic       ack;
   logic [7:0] tb_data;
   logic       tb_drive;
   logic       irq;
   wire  [7:0] bus_data;

   int total  = 0;
   int bad    = 0;
   int ecount = 0;

   // A released bus floats high, so high-Z reads as 8'hFF.
   assign bus_data = tb_drive ? tb_data : 8'bzzzz_zzzz;
   pullup (bus_data);

   bus_timer_multi #(
      .BASE_ADDR  (8'hF0),
      .NUM_CH     (NCH),
      .CLK_FREQ_HZ(100),
      .TICK_HZ    (10)
   ) dut (
      .CLK           (clk),
      .RESET         (rst),
      .BUS_DATA      (bus_data),
      .BUS_ADDR      (addr),
      .BUS_WE        (we),
      .SEND_INTERRUPT(irq),
      .INTERRUPT_ACK (ack)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ------------------------------------------------------ reference model
   int         m_pre;
   bit         m_en     [NCH];
   bit         m_ie     [NCH];
   bit         m_os     [NCH];
   int         m_period [NCH];
   int         m_count  [NCH];
   bit         m_exp    [NCH];
   bit         m_irq;
   bit         m_rd_en;
   logic [7:0] m_rd_data;

   task automatic model_reset();
      m_pre = 0; m_irq = 0; m_rd_en = 0; m_rd_data = 8'h00;
      for (int c = 0; c < NCH; c++) begin
         m_en[c] = 0; m_ie[c] = 0; m_os[c] = 0;
         m_period[c] = 0; m_count[c] = 0; m_exp[c] = 0;
      end
   endtask

   function automatic logic [7:0] reg_value(input int ch, input int k);
      case (k)
         0:       return {5'b00000, m_os[ch], m_ie[ch], m_en[ch]};
         1:       return 8'(m_period[ch]);
         2:       return 8'(m_count[ch]);
         default: return {7'b0000000, m_exp[ch]};
      endcase
   endfunction

   task automatic model_edge();
      int off, ch, k;
      bit win, tick, raise, active;
      bit fired [NCH];
      tick  = (m_pre == PRE - 1);
      off   = int'(addr) - 'hF0;
      win   = (off >= 0) && (off < 4 * NCH);
      ch    = win ? off / 4 : 0;
      k     = win ? off % 4 : 0;
      m_rd_en = win && !we;
      if (win) m_rd_data = reg_value(ch, k);
      raise = 0;
      for (int c = 0; c < NCH; c++) begin
         active   = tick && m_en[c] && (m_period[c] != 0);
         fired[c] = active && (m_count[c] + 1 >= m_period[c]);
         if (fired[c]) begin
            m_count[c] = 0;
            m_exp[c]   = 1;
            if (m_os[c]) m_en[c] = 0;
            if (m_ie[c]) raise = 1;
         end else if (active) begin
            m_count[c] = m_count[c] + 1;
         end
      end
      if (win && we) begin
         case (k)
            0: begin m_en[ch] = tb_data[0]; m_ie[ch] = tb_data[1]; m_os[ch] = tb_data[2]; end
            1: m_period[ch] = int'(tb_data);
            2: m_count[ch] = 0;
            default: if (!fired[ch]) m_exp[ch] = 0;
         endcase
      end
      if (raise) m_irq = 1;
      else if (ack) m_irq = 0;
      m_pre = (m_pre + 1) % PRE;
   endtask

   // ------------------------------------------------------------- helpers
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle();
      logic [7:0] exp_bus;
      @(posedge clk);
      model_edge();
      ecount++;
      #1;
      exp_bus = m_rd_en ? m_rd_data : (tb_drive ? tb_data : 8'hFF);
      chk("model_irq", {7'b0, irq}, {7'b0, m_irq});
      chk("model_bus", bus_data, exp_bus);
   endtask

   task automatic idle_inputs();
      addr = 8'h00; we = 1'b0; tb_drive = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; ack = 1'b0; tb_data = 8'h00;
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_irq", {7'b0, irq}, 8'h00);
      chk("reset_bus", bus_data, 8'hFF);
      rst = 1'b0;
      model_reset();
      ecount = 0;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      addr = a; we = 1'b1; tb_data = d; tb_drive = 1'b1;
      cycle();
      idle_inputs();
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
      addr = a; we = 1'b0; tb_drive = 1'b0;
      cycle();
      d = bus_data;
      idle_inputs();
      cycle();
   endtask

   task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
      logic [7:0] d;
      bus_read(a, d);
      chk(name, d, exp);
   endtask

   task automatic run_until_phase(input int p);
      for (int i = 0; i < PRE && (ecount % PRE) != p; i++) cycle();
   endtask

   task automatic run_ticks(input int n);
      int seen = 0;
      for (int i = 0; i < PRE * n + PRE && seen < n; i++) begin
         cycle();
         if (ecount % PRE == 0) seen++;
      end
   endtask

   task automatic wait_irq(input int limit, output int t);
      t = -1;
      for (int i = 0; i < limit; i++) begin
         cycle();
         if (irq) begin
            t = ecount;
            break;
         end
      end
   endtask

   task automatic ack_cycle();
      ack = 1'b1;
      cycle();
      ack = 1'b0;
   endtask

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t       tbl [$];
   int         t1, t2;
   bit         seen_irq;
   logic [7:0] a, d;
   int         r;

   initial begin
      // ---------------- table: reset values, decode, read-back, ignored writes
      tbl.push_back('{1'b0, 8'hEF, 8'h00, 8'hFF});
      tbl.push_back('{1'b0, 8'hF8, 8'h00, 8'hFF});
      for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 8'(8'hF0 + i), 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'hF1, 8'hA5, 8'h00});
      tbl.push_back('{1'b0, 8'hF1, 8'h00, 8'hA5});
      tbl.push_back('{1'b1, 8'hF0, 8'hFE, 8'h00});
      tbl.push_back('{1'b0, 8'hF0, 8'h00, 8'h06});
      tbl.push_back('{1'b1, 8'hF5, 8'h3C, 8'h00});
      tbl.push_back('{1'b0, 8'hF5, 8'h00, 8'h3C});
      tbl.push_back('{1'b1, 8'hF8, 8'h77, 8'h00});
      tbl.push_back('{1'b0, 8'hF0, 8'h00, 8'h06});
      tbl.push_back('{1'b0, 8'hF4, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'hEF, 8'h11, 8'h00});
      tbl.push_back('{1'b0, 8'hF1, 8'h00, 8'hA5});
      tbl.push_back('{1'b1, 8'hF2, 8'h99, 8'h00});
      tbl.push_back('{1'b0, 8'hF2, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'hF3, 8'h44, 8'h00});
      tbl.push_back('{1'b0, 8'hF3, 8'h00, 8'h00});
      tbl.push_back('{1'b0, 8'hFC, 8'h00, 8'hFF});

      do_reset();
      foreach (tbl[i]) begin
         if (tbl[i].we) begin
            bus_write(tbl[i].addr, tbl[i].data);
         end else begin
            bus_read(tbl[i].addr, d);
            chk($sformatf("tbl[%0d] @%h", i, tbl[i].addr), d, tbl[i].exp);
         end
      end

      // ---------------- periodic channel 0, period 3 ticks = 30 clocks
      do_reset();
      bus_write(8'hF1, 8'd3);
      bus_write(8'hF0, 8'h03);
      wait_irq(100, t1);
      chki("periodic first expiry edge", t1, 30);
      ack_cycle();
      chk("irq dropped after ack", {7'b0, irq}, 8'h00);
      read_chk("count after expiry", 8'hF2, 8'h00);
      read_chk("status after expiry", 8'hF3, 8'h01);
      wait_irq(100, t2);
      chki("periodic second expiry edge", t2, 60);
      run_ticks(1);
      read_chk("count 1", 8'hF2, 8'h01);
      run_ticks(1);
      read_chk("count 2", 8'hF2, 8'h02);

      // ---------------- one-shot channel 1
      do_reset();
      bus_write(8'hF4, 8'h05);
      bus_write(8'hF5, 8'd2);
      run_ticks(1);
      read_chk("oneshot not yet", 8'hF7, 8'h00);
      run_ticks(1);
      read_chk("oneshot expired", 8'hF7, 8'h01);
      read_chk("oneshot ctrl", 8'hF4, 8'h04);
      seen_irq = 0;
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (irq) seen_irq = 1;
      end
      chk("oneshot no irq", {7'b0, seen_irq}, 8'h00);
      read_chk("oneshot count held", 8'hF6, 8'h00);

      // ---------------- STATUS write on the expiry edge, ACK on an expiry edge
      do_reset();
      bus_write(8'hF1, 8'd1);
      bus_write(8'hF0, 8'h01);
      run_until_phase(9);
      bus_write(8'hF3, 8'h00);
      read_chk("status set beats clear", 8'hF3, 8'h01);
      run_until_phase(3);
      bus_write(8'hF3, 8'h00);
      read_chk("status cleared", 8'hF3, 8'h00);
      bus_write(8'hF0, 8'h03);
      wait_irq(20, t1);
      chki("ch0 irq edge", t1, 20);
      bus_write(8'hF0, 8'h00);
      bus_write(8'hF5, 8'd1);
      bus_write(8'hF4, 8'h03);
      run_until_phase(4);
      ack_cycle();
      chk("ack clears irq", {7'b0, irq}, 8'h00);
      run_until_phase(9);
      ack_cycle();
      chk("event beats ack", {7'b0, irq}, 8'h01);

      // ---------------- shrink PERIOD below COUNT
      do_reset();
      bus_write(8'hF1, 8'd10);
      bus_write(8'hF0, 8'h01);
      for (int i = 0; i < 100 && ecount < 70; i++) cycle();
      bus_write(8'hF1, 8'd4);
      read_chk("count 7", 8'hF2, 8'h07);
      read_chk("no expiry yet", 8'hF3, 8'h00);
      for (int i = 0; i < 20 && ecount < 81; i++) cycle();
      read_chk("forced expiry", 8'hF3, 8'h01);
      read_chk("count wrapped", 8'hF2, 8'h00);

      // ---------------- PERIOD=0 holds, then COUNT write mid-run
      do_reset();
      bus_write(8'hF0, 8'h03);
      seen_irq = 0;
      for (int i = 0; i < 1000; i++) begin
         cycle();
         if (irq) seen_irq = 1;
      end
      chk("period0 no irq", {7'b0, seen_irq}, 8'h00);
      read_chk("period0 count", 8'hF2, 8'h00);
      read_chk("period0 status", 8'hF3, 8'h00);
      bus_write(8'hF1, 8'd100);
      run_ticks(5);
      read_chk("count 5", 8'hF2, 8'h05);
      bus_write(8'hF2, 8'h55);
      read_chk("count write zero", 8'hF2, 8'h00);

      // ---------------- read latency and asynchronous reset while driving
      do_reset();
      bus_write(8'hF0, 8'h03);
      bus_write(8'hF1, 8'h5A);
      addr = 8'hF1; we = 1'b0;
      #1;
      chk("latency before edge", bus_data, 8'hFF);
      cycle();
      chk("latency one cycle", bus_data, 8'h5A);
      idle_inputs();
      cycle();
      chk("release after leave", bus_data, 8'hFF);
      addr = 8'hF1;
      cycle();
      chk("driving before reset", bus_data, 8'h5A);
      #2;
      rst = 1'b1;
      #1;
      chk("async release", bus_data, 8'hFF);
      idle_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      ecount = 0;
      for (int i = 0; i < 8; i++) read_chk($sformatf("post reset @%h", 8'(8'hF0 + i)), 8'(8'hF0 + i), 8'h00);

      // ---------------- randomized traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         a = 8'($urandom_range(8'hEC, 8'hFB));
         if (r < 4) begin
            cycle();
         end else if (r < 6) begin
            bus_read(a, d);
         end else if (r < 9) begin
            if (a[1:0] == 2'd1) d = 8'($urandom_range(0, 4));
            else                d = 8'($urandom_range(0, 255));
            bus_write(a, d);
         end else begin
            ack_cycle();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
